// File: rtl/countdown_pkg.sv
// Shared types and rate-select encodings for the countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] RATE_FAST = 2'b00;
  localparam logic [1:0] RATE_1HZ  = 2'b01;
  localparam logic [1:0] RATE_HALF = 2'b10;
  localparam logic [1:0] RATE_QTR  = 2'b11;

endpackage

// File: rtl/rate_divider.sv
// Tick generator: a down-counting divider that is reloaded with the period
// selected by i_rate_sel each time it reaches zero or is restarted.
module rate_divider
  import countdown_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_run,
  input  logic       i_enable,
  input  logic       i_restart,
  input  logic [1:0] i_rate_sel,
  output logic       o_tick
);

  localparam int DIV_W = $clog2(4 * CLK_HZ);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_period_m1;

  // Rate select is only consulted when the counter reloads, so a change
  // mid-period never shortens or stretches the period in flight.
  always_comb begin
    w_period_m1 = '0;
    case (i_rate_sel)
      RATE_FAST: w_period_m1 = '0;
      RATE_1HZ:  w_period_m1 = DIV_W'(CLK_HZ - 1);
      RATE_HALF: w_period_m1 = DIV_W'(2 * CLK_HZ - 1);
      RATE_QTR:  w_period_m1 = DIV_W'(4 * CLK_HZ - 1);
      default:   w_period_m1 = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div <= '0;
    end else if (i_restart) begin
      r_div <= w_period_m1;
    end else if (i_run && i_enable) begin
      r_div <= (r_div == '0) ? w_period_m1 : r_div - 1'b1;
    end
  end

  assign o_tick = i_run & i_enable & (r_div == '0) & ~i_restart;

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with selectable tick rate and one-cycle expiry pulse.
// Define AUTO_RELOAD_EN to wrap back to the loaded value instead of stopping.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int WIDTH  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_enable,
  input  logic [1:0]       i_rate_sel,
  output logic [WIDTH-1:0] o_q,
  output logic             o_running,
  output logic             o_done,
  output logic             o_tick
);

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_q, w_q_next;
  logic             r_done, w_done_next;
  logic             w_run;
  logic             w_tick;
`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload, w_reload_next;
`endif

  assign w_run = (r_state == RUN);

  rate_divider #(
    .CLK_HZ(CLK_HZ)
  ) u_rate_divider (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_run      (w_run),
    .i_enable   (i_enable),
    .i_restart  (i_load),
    .i_rate_sel (i_rate_sel),
    .o_tick     (w_tick)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_done_next  = 1'b0;
`ifdef AUTO_RELOAD_EN
    w_reload_next = r_reload;
`endif
    if (i_load) begin
      w_q_next = i_load_value;
`ifdef AUTO_RELOAD_EN
      w_reload_next = i_load_value;
`endif
      if (i_load_value != '0) begin
        w_state_next = RUN;
      end else begin
        w_state_next = DONE;
        w_done_next  = 1'b1;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (w_tick) begin
            if (r_q == WIDTH'(1)) begin
`ifdef AUTO_RELOAD_EN
              w_q_next     = r_reload;
              w_done_next  = 1'b1;
`else
              w_q_next     = '0;
              w_state_next = DONE;
              w_done_next  = 1'b1;
`endif
            end else begin
              w_q_next = r_q - 1'b1;
            end
          end
        end
        DONE:    w_state_next = IDLE;
        IDLE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_done   <= 1'b0;
`ifdef AUTO_RELOAD_EN
      r_reload <= '0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_q      <= w_q_next;
      r_done   <= w_done_next;
`ifdef AUTO_RELOAD_EN
      r_reload <= w_reload_next;
`endif
    end
  end

  assign o_q       = r_q;
  assign o_running = w_run;
  assign o_done    = r_done;
  assign o_tick    = w_tick;

endmodule
